// File: rtl/mx_dual_phy_pkg.sv
// rtl/mx_dual_phy_pkg.sv - shared port indices, switch FSM states and counter helpers
// Used by the dual-PHY TX/RX select logic.
package mx_dual_phy_pkg;

  localparam int unsigned XGE   = 0;
  localparam int unsigned GBE   = 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_WAIT_EOP = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_SWITCH   = 2'd3
  } sw_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mx_tx_port_switch_ctrl_if.sv
// rtl/mx_tx_port_switch_ctrl_if.sv - TX stream and per-port status bundle around the switch controller
// master: upstream/demux side; slave: the controller.
interface mx_tx_port_switch_ctrl_if;

  logic       pkt_val;
  logic       pkt_sop;
  logic       pkt_eop;
  logic       pkt_full;
  logic [1:0] port_full;
  logic [1:0] port_empty;
  logic       sel;

  modport master (
    output pkt_val, pkt_sop, pkt_eop, port_full, port_empty,
    input  pkt_full, sel
  );

  modport slave (
    input  pkt_val, pkt_sop, pkt_eop, port_full, port_empty,
    output pkt_full, sel
  );

endinterface

// File: rtl/mx_bit_sync.sv
// rtl/mx_bit_sync.sv - two-flop synchronizer with configurable reset value
// Shared by the TX and RX port-select paths.
module mx_bit_sync #(
  parameter int unsigned WIDTH             = 1,
  parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/mx_tx_port_switch_ctrl.sv
// rtl/mx_tx_port_switch_ctrl.sv - moves the TX stream between XGE and GBE at packet boundaries after draining
// Optional statistics counters: MX_TX_SW_STAT_EN.
module mx_tx_port_switch_ctrl
  import mx_dual_phy_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 64,
  parameter int unsigned RESET_SEL    = 0
) (
  input  logic                      xgmii_clk_i,
  input  logic                      rst_i,
  input  logic                      sel_req_i,
  mx_tx_port_switch_ctrl_if.slave   tx_if,
  output logic                      switching_o,
  output logic [CNT_W-1:0]          switch_cnt_o,
  output logic [CNT_W-1:0]          abort_cnt_o
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);
  localparam logic RST_SEL_B = 1'(RESET_SEL);

  sw_state_e      r_state;
  logic           r_sel;
  logic           r_target;
  logic           r_switching;
  logic           r_in_pkt;
  logic [DCW-1:0] r_drain_cnt;

  logic w_req_s;
  logic w_beat_sop;
  logic w_beat_eop;
  logic w_go_drain;
  logic w_old_empty;

  mx_bit_sync #(.WIDTH(1), .RESET_VAL(RST_SEL_B)) u_req_sync (
    .clk_i (xgmii_clk_i),
    .rst_i (rst_i),
    .d_i   (sel_req_i),
    .q_o   (w_req_s)
  );

  assign w_beat_sop  = tx_if.pkt_val & tx_if.pkt_sop;
  assign w_beat_eop  = tx_if.pkt_val & tx_if.pkt_eop;
  assign w_old_empty = tx_if.port_empty[r_sel];
  // An eop arriving with the mismatch closes the packet, so skip WAIT_EOP.
  assign w_go_drain  = (!r_in_pkt && !w_beat_sop) || w_beat_eop;

  assign tx_if.pkt_full = ((r_state == ST_DRAIN) || (r_state == ST_SWITCH)) ? 1'b1
                                                                             : tx_if.port_full[r_sel];
  assign tx_if.sel      = r_sel;
  assign switching_o    = r_switching;

  always_ff @(posedge xgmii_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_in_pkt <= 1'b0;
    end else if (w_beat_eop) begin
      r_in_pkt <= 1'b0;
    end else if (w_beat_sop) begin
      r_in_pkt <= 1'b1;
    end
  end

  always_ff @(posedge xgmii_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_RUN;
      r_sel       <= RST_SEL_B;
      r_target    <= RST_SEL_B;
      r_switching <= 1'b0;
      r_drain_cnt <= DRAIN_LOAD;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_req_s != r_sel) begin
            r_target <= w_req_s;
            if (w_go_drain) begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
              r_switching <= 1'b1;
            end else begin
              r_state <= ST_WAIT_EOP;
            end
          end
        end
        ST_WAIT_EOP: begin
          if (w_req_s == r_sel) begin
            r_state <= ST_RUN;
          end else if (w_beat_eop) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
            r_switching <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_req_s == r_sel) begin
            r_state     <= ST_RUN;
            r_switching <= 1'b0;
          end else begin
            r_target <= w_req_s;
            // Any busy cycle restarts the quiet-period count.
            if (!w_old_empty) begin
              r_drain_cnt <= DRAIN_LOAD;
            end else if (r_drain_cnt == DCW'(1)) begin
              r_state <= ST_SWITCH;
            end else begin
              r_drain_cnt <= r_drain_cnt - DCW'(1);
            end
          end
        end
        ST_SWITCH: begin
          r_sel       <= r_target;
          r_state     <= ST_RUN;
          r_switching <= 1'b0;
        end
        default: begin
          r_state     <= ST_RUN;
          r_switching <= 1'b0;
        end
      endcase
    end
  end

`ifdef MX_TX_SW_STAT_EN
  logic             w_abort_evt;
  logic             w_switch_evt;
  logic [CNT_W-1:0] r_switch_cnt;
  logic [CNT_W-1:0] r_abort_cnt;

  assign w_switch_evt = (r_state == ST_SWITCH);
  assign w_abort_evt  = ((r_state == ST_WAIT_EOP) || (r_state == ST_DRAIN)) && (w_req_s == r_sel);

  always_ff @(posedge xgmii_clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_switch_cnt <= '0;
      r_abort_cnt  <= '0;
    end else begin
      if (w_switch_evt) r_switch_cnt <= sat_inc(r_switch_cnt);
      if (w_abort_evt)  r_abort_cnt  <= sat_inc(r_abort_cnt);
    end
  end

  assign switch_cnt_o = r_switch_cnt;
  assign abort_cnt_o  = r_abort_cnt;
`else
  assign switch_cnt_o = '0;
  assign abort_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_mx_tx_port_switch_ctrl.sv
// tb/tb_mx_tx_port_switch_ctrl.sv - directed self-checking bench for mx_tx_port_switch_ctrl
// Counter expectations follow MX_TX_SW_STAT_EN.
module tb_mx_tx_port_switch_ctrl;

`ifdef MX_TX_SW_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst0, rst1, req0, req1;
  logic        sw0, sw1;
  logic [15:0] scnt0, acnt0, scnt1, acnt1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mx_tx_port_switch_ctrl_if if0 ();
  mx_tx_port_switch_ctrl_if if1 ();

  mx_tx_port_switch_ctrl #(.DRAIN_CYCLES(4), .RESET_SEL(0)) dut0 (
    .xgmii_clk_i (clk),
    .rst_i       (rst0),
    .sel_req_i   (req0),
    .tx_if       (if0),
    .switching_o (sw0),
    .switch_cnt_o(scnt0),
    .abort_cnt_o (acnt0)
  );

  mx_tx_port_switch_ctrl #(.DRAIN_CYCLES(4), .RESET_SEL(1)) dut1 (
    .xgmii_clk_i (clk),
    .rst_i       (rst1),
    .sel_req_i   (req1),
    .tx_if       (if1),
    .switching_o (sw1),
    .switch_cnt_o(scnt1),
    .abort_cnt_o (acnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat0(input logic v, input logic s, input logic e);
    if0.pkt_val = v;
    if0.pkt_sop = s;
    if0.pkt_eop = e;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    req0 = 1'b0; req1 = 1'b1;
    beat0(1'b0, 1'b0, 1'b0);
    if1.pkt_val = 1'b0; if1.pkt_sop = 1'b0; if1.pkt_eop = 1'b0;
    if0.port_full = 2'b10; if0.port_empty = 2'b11;
    if1.port_full = 2'b01; if1.port_empty = 2'b11;
    #1;
    checks++; if (if0.sel !== 1'b0) begin errors++; $display("FAIL rst_sel0 got %b exp 0", if0.sel); end
    checks++; if (if0.pkt_full !== 1'b0) begin errors++; $display("FAIL rst_full0 got %b exp 0", if0.pkt_full); end
    checks++; if (sw0 !== 1'b0) begin errors++; $display("FAIL rst_sw0 got %b exp 0", sw0); end
    checks++; if (scnt0 !== 16'h0 || acnt0 !== 16'h0) begin errors++; $display("FAIL rst_cnt0 got %h/%h exp 0/0", scnt0, acnt0); end
    checks++; if (if1.sel !== 1'b1) begin errors++; $display("FAIL rst_sel1 got %b exp 1", if1.sel); end
    checks++; if (if1.pkt_full !== 1'b0) begin errors++; $display("FAIL rst_full1 got %b exp 0", if1.pkt_full); end
    if0.port_full = 2'b01;
    #1;
    checks++; if (if0.pkt_full !== 1'b1) begin errors++; $display("FAIL rst_full0_comb got %b exp 1", if0.pkt_full); end
    step(); step();
    rst0 = 1'b0; rst1 = 1'b0;
    if0.port_full = 2'b00;
    step(); step();
  endtask

  task automatic test_idle_switch();
    req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (if0.sel !== (k >= 8)) begin errors++; $display("FAIL idle_sel edge %0d got %b exp %b", k, if0.sel, (k >= 8)); end
      checks++; if (if0.pkt_full !== (k >= 3 && k <= 7)) begin errors++; $display("FAIL idle_full edge %0d got %b exp %b", k, if0.pkt_full, (k >= 3 && k <= 7)); end
      checks++; if (sw0 !== (k >= 3 && k <= 7)) begin errors++; $display("FAIL idle_sw edge %0d got %b exp %b", k, sw0, (k >= 3 && k <= 7)); end
    end
    checks++; if (scnt0 !== 16'(STAT)) begin errors++; $display("FAIL idle_scnt got %0d exp %0d", scnt0, STAT); end
    step();
  endtask

  task automatic test_pkt_wait();
    req0 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (k <= 10) beat0(1'b1, k == 1, k == 10);
      else beat0(1'b0, 1'b0, 1'b0);
      step();
      checks++; if (if0.sel !== (k <= 14)) begin errors++; $display("FAIL pkt_sel edge %0d got %b exp %b", k, if0.sel, (k <= 14)); end
      if (k <= 9) begin
        checks++; if (sw0 !== 1'b0 || if0.pkt_full !== 1'b0) begin errors++; $display("FAIL pkt_wait edge %0d got sw=%b full=%b exp 0/0", k, sw0, if0.pkt_full); end
      end else if (k <= 14) begin
        checks++; if (sw0 !== 1'b1) begin errors++; $display("FAIL pkt_drain edge %0d got %b exp 1", k, sw0); end
      end
    end
    beat0(1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_busy_drain();
    req0 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      if0.port_empty = (k == 6) ? 2'b10 : 2'b11;
      step();
      checks++; if (if0.sel !== (k >= 11)) begin errors++; $display("FAIL busy_sel edge %0d got %b exp %b", k, if0.sel, (k >= 11)); end
    end
    if0.port_empty = 2'b11;
    checks++; if (scnt0 !== 16'(3 * STAT)) begin errors++; $display("FAIL busy_scnt got %0d exp %0d", scnt0, 3 * STAT); end
    step();
  endtask

  task automatic test_revert();
    req0 = 1'b0;
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    step(); step();
    req0 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) req0 = 1'b0;
      checks++; if (if0.sel !== 1'b0) begin errors++; $display("FAIL rev_sel edge %0d got %b exp 0", k, if0.sel); end
      if (k >= 3) begin
        checks++; if (sw0 !== (k <= 5)) begin errors++; $display("FAIL rev_sw edge %0d got %b exp %b", k, sw0, (k <= 5)); end
      end
    end
    checks++; if (acnt0 !== 16'(STAT)) begin errors++; $display("FAIL rev_acnt got %0d exp %0d", acnt0, STAT); end
    checks++; if (scnt0 !== 16'h0) begin errors++; $display("FAIL rev_scnt got %0d exp 0", scnt0); end
  endtask

  task automatic test_eop_at_mismatch();
    req0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 3) beat0(1'b1, k == 1, k == 3);
      else beat0(1'b0, 1'b0, 1'b0);
      step();
      checks++; if (if0.sel !== (k >= 8)) begin errors++; $display("FAIL eopm_sel edge %0d got %b exp %b", k, if0.sel, (k >= 8)); end
      if (k == 3) begin
        checks++; if (sw0 !== 1'b1) begin errors++; $display("FAIL eopm_direct got %b exp 1", sw0); end
      end
    end
    checks++; if (scnt0 !== 16'(STAT)) begin errors++; $display("FAIL eopm_scnt got %0d exp %0d", scnt0, STAT); end
    step();
  endtask

  task automatic test_eop_revert();
    req0 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 6) beat0(1'b1, k == 1, k == 6);
      else beat0(1'b0, 1'b0, 1'b0);
      step();
      if (k == 3) req0 = 1'b1;
      checks++; if (if0.sel !== 1'b1 || sw0 !== 1'b0) begin errors++; $display("FAIL eoprev edge %0d got sel=%b sw=%b exp 1/0", k, if0.sel, sw0); end
    end
    checks++; if (acnt0 !== 16'(2 * STAT)) begin errors++; $display("FAIL eoprev_acnt got %0d exp %0d", acnt0, 2 * STAT); end
  endtask

  task automatic test_reset_mid_drain();
    req1 = 1'b0;
    for (int k = 1; k <= 8; k++) step();
    checks++; if (if1.sel !== 1'b0) begin errors++; $display("FAIL r1_sel got %b exp 0", if1.sel); end
    checks++; if (scnt1 !== 16'(STAT)) begin errors++; $display("FAIL r1_scnt got %0d exp %0d", scnt1, STAT); end
    checks++; if (if1.pkt_full !== 1'b1) begin errors++; $display("FAIL r1_full_xge got %b exp 1", if1.pkt_full); end
    req1 = 1'b1;
    for (int k = 1; k <= 4; k++) step();
    checks++; if (sw1 !== 1'b1 || if1.sel !== 1'b0) begin errors++; $display("FAIL r1_middrain got sw=%b sel=%b exp 1/0", sw1, if1.sel); end
    rst1 = 1'b1;
    #1;
    checks++; if (if1.sel !== 1'b1) begin errors++; $display("FAIL r1_rst_sel got %b exp 1", if1.sel); end
    checks++; if (if1.pkt_full !== 1'b0) begin errors++; $display("FAIL r1_rst_full got %b exp 0", if1.pkt_full); end
    checks++; if (sw1 !== 1'b0 || scnt1 !== 16'h0 || acnt1 !== 16'h0) begin errors++; $display("FAIL r1_rst_misc got sw=%b cnt=%0d/%0d exp 0/0/0", sw1, scnt1, acnt1); end
    step();
    rst1 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++; if (if1.sel !== 1'b1 || sw1 !== 1'b0) begin errors++; $display("FAIL r1_post edge %0d got sel=%b sw=%b exp 1/0", k, if1.sel, sw1); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_switch();
    test_pkt_wait();
    test_busy_drain();
    test_revert();
    test_eop_at_mismatch();
    test_eop_revert();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
